// File: rtl/adc_target_pkg.sv
// Shared types and register constants for the ADC SPI target emulator.
package adc_target_pkg;

    typedef enum logic [1:0] {
        ONE  = 2'b00,
        TWO  = 2'b01,
        FOUR = 2'b10
    } lane_mode_e;

    typedef enum logic {
        CONVERSION = 1'b0,
        REG_ACCESS = 1'b1
    } dev_mode_e;

    localparam logic [14:0] REG_MODE_ADDR = 15'h0020;
    localparam logic [14:0] REG_EXIT_ADDR = 15'h0014;
    localparam logic [2:0]  REG_ENTRY_OP  = 3'b101;

    // Code 2'b11 is kept in the register but reads out as a single lane.
    function automatic logic [2:0] lane_count(input logic [1:0] lm);
        case (lm)
            TWO:     lane_count = 3'd2;
            FOUR:    lane_count = 3'd4;
            default: lane_count = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/adc_target_sync.sv
// Multi-stage input synchroniser with rise/fall detection on the synchronised level.
module adc_target_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/adc_spi_target.sv
// SPI responder emulating the converter side of the adc_manager link.
// Build option ADC_TARGET_CNT_PATTERN_EN replaces sample_data with an internal counting pattern.
module adc_spi_target
    import adc_target_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CNV_CYCLES  = 28,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  spi_cnv,
    output logic                  spi_busy,
    input  logic                  spi_sck,
    input  logic                  spi_csn,
    input  logic                  spi_resetn,
    input  logic                  spi_sdi,
    output logic [3:0]            spi_sdo,
    input  logic [DATA_WIDTH-1:0] sample_data,
    output logic                  sample_req,
    output logic [1:0]            lane_mode,
    output logic                  reg_mode,
    output logic                  cmd_valid,
    output logic [23:0]           cmd_data
);

    localparam int IDX_W = $clog2(DATA_WIDTH + 1);
    localparam int CNT_W = (CNV_CYCLES > 1) ? $clog2(CNV_CYCLES) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    logic cnv_rise, sck_rise, csn_q, csn_rise, csn_fall, sdi_q, srst_q, soft_rst;
    logic unused_cnv_q, unused_cnv_fall, unused_sck_q, unused_sck_fall;
    logic unused_sdi_rise, unused_sdi_fall, unused_srst_rise, unused_srst_fall;

    adc_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cnv (
        .clk(clk), .resetn(resetn), .din(spi_cnv),
        .q(unused_cnv_q), .rise(cnv_rise), .fall(unused_cnv_fall));
    adc_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .resetn(resetn), .din(spi_sck),
        .q(unused_sck_q), .rise(sck_rise), .fall(unused_sck_fall));
    adc_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
        .clk(clk), .resetn(resetn), .din(spi_csn),
        .q(csn_q), .rise(csn_rise), .fall(csn_fall));
    adc_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .resetn(resetn), .din(spi_sdi),
        .q(sdi_q), .rise(unused_sdi_rise), .fall(unused_sdi_fall));
    adc_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_srst (
        .clk(clk), .resetn(resetn), .din(spi_resetn),
        .q(srst_q), .rise(unused_srst_rise), .fall(unused_srst_fall));

    assign soft_rst = ~srst_q;

    logic [0:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] capture_word;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_next;
    logic [23:0]           shreg;
    logic                  data_ready;
    logic                  capture;
    dev_mode_e             dev_mode;

    assign capture  = (state == ST_CONV) && (cnt == '0);
    assign idx_next = idx - IDX_W'(lane_count(lane_mode));
    assign reg_mode = (dev_mode == REG_ACCESS);

`ifdef ADC_TARGET_CNT_PATTERN_EN
    logic [DATA_WIDTH-1:0] pat_cnt;
    logic                  unused_sample;
    assign unused_sample = ^sample_data;
    assign capture_word  = pat_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pat_cnt <= '0;
        end else if (soft_rst) begin
            pat_cnt <= '0;
        end else if (capture) begin
            pat_cnt <= pat_cnt + 1'b1;
        end
    end
`else
    assign capture_word = sample_data;
`endif

    // Align the group ending at bit idx-1 to the top, then lane k takes word[idx-1-k].
    function automatic logic [3:0] group_at(input logic [DATA_WIDTH-1:0] w,
                                            input logic [IDX_W-1:0] i,
                                            input logic [1:0] lm);
        logic [DATA_WIDTH-1:0] aligned;
        logic [3:0]            g;
        aligned = w << (IDX_W'(DATA_WIDTH) - i);
        g       = 4'b0000;
        g[0]    = aligned[DATA_WIDTH-1];
        if (lm == TWO || lm == FOUR) g[1] = aligned[DATA_WIDTH-2];
        if (lm == FOUR) g[3:2] = {aligned[DATA_WIDTH-4], aligned[DATA_WIDTH-3]};
        return g;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;  cnt <= '0;  word <= '0;  idx <= '0;  shreg <= '0;
            data_ready <= 1'b0;  spi_busy <= 1'b0;  spi_sdo <= 4'b0;  sample_req <= 1'b0;
            lane_mode <= ONE;  dev_mode <= CONVERSION;  cmd_valid <= 1'b0;  cmd_data <= '0;
        end else if (soft_rst) begin
            state <= ST_IDLE;  cnt <= '0;  word <= '0;  idx <= '0;  shreg <= '0;
            data_ready <= 1'b0;  spi_busy <= 1'b0;  spi_sdo <= 4'b0;  sample_req <= 1'b0;
            lane_mode <= ONE;  dev_mode <= CONVERSION;  cmd_valid <= 1'b0;  cmd_data <= '0;
        end else begin
            sample_req <= 1'b0;
            cmd_valid  <= 1'b0;

            // A cnv rise while idle (even mid-readout) discards the pending word.
            if (state == ST_IDLE) begin
                if (cnv_rise) begin
                    state      <= ST_CONV;
                    spi_busy   <= 1'b1;
                    cnt        <= CNT_W'(CNV_CYCLES - 1);
                    data_ready <= 1'b0;
                end
            end else if (capture) begin
                state      <= ST_IDLE;
                spi_busy   <= 1'b0;
                word       <= capture_word;
                sample_req <= 1'b1;
                data_ready <= 1'b1;
                idx        <= IDX_W'(DATA_WIDTH);
            end else begin
                cnt <= cnt - 1'b1;
            end

            if (csn_fall) begin
                shreg   <= '0;
                spi_sdo <= (data_ready && dev_mode == CONVERSION) ?
                           group_at(word, idx, lane_mode) : 4'b0000;
            end else if (!csn_q && sck_rise) begin
                shreg <= {shreg[22:0], sdi_q};
                if (data_ready && dev_mode == CONVERSION) begin
                    idx <= idx_next;
                    if (idx_next == '0) data_ready <= 1'b0;
                    else                spi_sdo    <= group_at(word, idx_next, lane_mode);
                end
            end

            if (csn_rise) begin
                cmd_valid <= 1'b1;
                cmd_data  <= shreg;
                if (shreg[23:21] == REG_ENTRY_OP) begin
                    dev_mode <= REG_ACCESS;
                end else if (dev_mode == REG_ACCESS && shreg[23:8] == {1'b0, REG_MODE_ADDR}) begin
                    lane_mode <= shreg[7:6];
                end else if (dev_mode == REG_ACCESS && shreg[23:8] == {1'b0, REG_EXIT_ADDR}
                             && shreg[0]) begin
                    dev_mode <= CONVERSION;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_target.sv
// Directed bench for adc_spi_target: readout groups and command frames scored through queues.
module tb_adc_spi_target;

    logic        clk;
    logic        resetn;
    logic        spi_cnv;
    logic        spi_busy;
    logic        spi_sck;
    logic        spi_csn;
    logic        spi_resetn;
    logic        spi_sdi;
    logic [3:0]  spi_sdo;
    logic [31:0] sample_data;
    logic        sample_req;
    logic [1:0]  lane_mode;
    logic        reg_mode;
    logic        cmd_valid;
    logic [23:0] cmd_data;

    int total = 0;
    int bad   = 0;
    int sreq_cnt = 0;
    int len;
    logic [3:0]  sdo_q[$];
    logic [23:0] cmd_q[$];
    logic [3:0]  last_exp;

    adc_spi_target #(.DATA_WIDTH(32), .CNV_CYCLES(28), .SYNC_STAGES(2)) dut (
        .clk(clk), .resetn(resetn), .spi_cnv(spi_cnv), .spi_busy(spi_busy),
        .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_resetn(spi_resetn), .spi_sdi(spi_sdi),
        .spi_sdo(spi_sdo), .sample_data(sample_data), .sample_req(sample_req),
        .lane_mode(lane_mode), .reg_mode(reg_mode), .cmd_valid(cmd_valid), .cmd_data(cmd_data));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive every SPI pin at once, then let the synchronisers settle.
    task automatic applyStimulus(input logic cnv_v, input logic csn_v,
                                 input logic sck_v, input logic sdi_v);
        @(negedge clk);
        spi_cnv = cnv_v;
        spi_csn = csn_v;
        spi_sck = sck_v;
        spi_sdi = sdi_v;
        repeat (4) @(negedge clk);
    endtask

    task automatic sck_cycle(input logic sdi_v);
        applyStimulus(1'b0, 1'b0, 1'b0, sdi_v);
        applyStimulus(1'b0, 1'b0, 1'b1, sdi_v);
    endtask

    task automatic csn_low();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic csn_high(input logic [23:0] exp_cmd);
        cmd_q.push_back(exp_cmd);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [23:0] f);
        csn_low();
        for (int i = 23; i >= 0; i--) sck_cycle(f[i]);
        csn_high(f);
    endtask

    // Expected lane groups: lane k carries word[idx-1-k] for idx = 32, 32-n, ...
    function automatic void push_word(input logic [31:0] w, input int n);
        logic [31:0] t;
        logic [3:0]  g;
        for (int i = 32; i > 0; i -= n) begin
            g = 4'b0000;
            for (int k = 0; k < n; k++) begin
                t = w >> (i - 1 - k);
                g = g | (4'(t[0]) << k);
            end
            sdo_q.push_back(g);
        end
    endfunction

    task automatic sdo_next(input string tag);
        if (sdo_q.size() == 0) begin
            checkOutput({tag, "_queue_empty"}, 32'(sdo_q.size()), 32'd1);
        end else begin
            last_exp = sdo_q.pop_front();
            checkOutput(tag, 32'(spi_sdo), 32'(last_exp));
        end
    endtask

    task automatic sdo_hold(input string tag);
        checkOutput(tag, 32'(spi_sdo), 32'(last_exp));
    endtask

    task automatic convert(input logic [31:0] w, input bit retrig, output int busy_len);
        sample_data = w;
        @(negedge clk);
        spi_cnv  = 1'b1;
        busy_len = 0;
        for (int i = 0; i < 10 && !spi_busy; i++) @(negedge clk);
        if (spi_busy) begin
            spi_cnv  = 1'b0;
            busy_len = 1;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (retrig && busy_len == 10) spi_cnv = 1'b1;
                if (retrig && busy_len == 13) spi_cnv = 1'b0;
                if (!spi_busy) break;
                busy_len++;
            end
        end
        spi_cnv = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (sample_req) sreq_cnt++;
        if (cmd_valid) begin
            if (cmd_q.size() == 0) checkOutput("cmd_unexpected", 32'(cmd_data), 32'hFFFF_FFFF);
            else                   checkOutput("cmd_data", 32'(cmd_data), 32'(cmd_q.pop_front()));
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        resetn = 1'b0;  spi_resetn = 1'b1;  spi_cnv = 1'b0;  spi_sck = 1'b0;
        spi_csn = 1'b1;  spi_sdi = 1'b0;  sample_data = '0;  last_exp = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy",      32'(spi_busy),   32'd0);
        checkOutput("rst_sdo",       32'(spi_sdo),    32'd0);
        checkOutput("rst_lane_mode", 32'(lane_mode),  32'd0);
        checkOutput("rst_reg_mode",  32'(reg_mode),   32'd0);
        checkOutput("rst_cmd_valid", 32'(cmd_valid),  32'd0);
        checkOutput("rst_cmd_data",  32'(cmd_data),   32'd0);
        checkOutput("rst_sample_req", 32'(sample_req), 32'd0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] one-lane readout");
        convert(32'h8BADF00D, 1'b0, len);
        checkOutput("busy_len", 32'(len), 32'd28);
        sdo_q.delete();
        push_word(32'h8BADF00D, 1);
        csn_low();
        sdo_next("l1_first");
        for (int i = 1; i < 32; i++) begin
            sck_cycle(1'b0);
            sdo_next("l1_bit");
        end
        sck_cycle(1'b0);
        sdo_hold("l1_end_hold");
        csn_high(24'h0);

        $display("[TB] register frames");
        send_frame(24'hA00000);
        checkOutput("reg_entry", 32'(reg_mode), 32'd1);
        send_frame(24'h002080);
        checkOutput("reg_still", 32'(reg_mode), 32'd1);
        checkOutput("lane_four", 32'(lane_mode), 32'd2);
        send_frame(24'h001401);
        checkOutput("reg_exit", 32'(reg_mode), 32'd0);
        checkOutput("cmd_last", 32'(cmd_data), 32'h001401);

        $display("[TB] four-lane readout");
        convert(32'h0023FF42, 1'b0, len);
        checkOutput("busy_len4", 32'(len), 32'd28);
        sdo_q.delete();
        push_word(32'h0023FF42, 4);
        csn_low();
        sdo_next("l4_first");
        for (int i = 1; i < 8; i++) begin
            sck_cycle(1'b0);
            sdo_next("l4_group");
        end
        sck_cycle(1'b0);
        sdo_hold("l4_end_hold");
        csn_high(24'h0);

        $display("[TB] two-lane readout with csn gap");
        send_frame(24'hA00000);
        send_frame(24'h002040);
        send_frame(24'h001401);
        checkOutput("lane_two", 32'(lane_mode), 32'd1);
        convert(32'hC3A51E96, 1'b0, len);
        sdo_q.delete();
        push_word(32'hC3A51E96, 2);
        csn_low();
        sdo_next("l2_first");
        for (int i = 0; i < 6; i++) begin
            sck_cycle(1'b0);
            sdo_next("l2_seg1");
        end
        csn_high(24'h0);
        csn_low();
        sdo_hold("l2_resume");
        for (int i = 0; i < 9; i++) begin
            sck_cycle(1'b0);
            sdo_next("l2_seg2");
        end
        sck_cycle(1'b0);
        sdo_hold("l2_end_hold");
        sck_cycle(1'b0);
        sdo_hold("l2_extra_sck");
        csn_high(24'h0);

        $display("[TB] cnv during conversion and partial readout restart");
        convert(32'h5A5A0FF0, 1'b1, len);
        checkOutput("busy_not_extended", 32'(len), 32'd28);
        sdo_q.delete();
        push_word(32'h5A5A0FF0, 2);
        csn_low();
        sdo_next("part_first");
        for (int i = 0; i < 5; i++) begin
            sck_cycle(1'b0);
            sdo_next("part_group");
        end
        csn_high(24'h0);
        convert(32'h13579BDF, 1'b0, len);
        sdo_q.delete();
        push_word(32'h13579BDF, 2);
        csn_low();
        sdo_next("new_first");
        for (int i = 1; i < 16; i++) begin
            sck_cycle(1'b0);
            sdo_next("new_group");
        end
        sck_cycle(1'b0);
        sdo_hold("new_end_hold");
        csn_high(24'h0);

        $display("[TB] device soft reset");
        convert(32'hFEDCBA98, 1'b0, len);
        sdo_q.delete();
        push_word(32'hFEDCBA98, 2);
        csn_low();
        sdo_next("srst_first");
        for (int i = 0; i < 3; i++) begin
            sck_cycle(1'b0);
            sdo_next("srst_group");
        end
        spi_resetn = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("srst_busy",      32'(spi_busy),   32'd0);
        checkOutput("srst_sdo",       32'(spi_sdo),    32'd0);
        checkOutput("srst_lane_mode", 32'(lane_mode),  32'd0);
        checkOutput("srst_reg_mode",  32'(reg_mode),   32'd0);
        checkOutput("srst_cmd_valid", 32'(cmd_valid),  32'd0);
        spi_resetn = 1'b1;
        repeat (4) @(negedge clk);
        sck_cycle(1'b0);
        checkOutput("srst_no_data", 32'(spi_sdo), 32'd0);
        csn_high(24'h0);
        checkOutput("srst_lane_after", 32'(lane_mode), 32'd0);
        send_frame(24'hA00000);
        checkOutput("srst_reg_entry", 32'(reg_mode), 32'd1);
        spi_resetn = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("srst_reg_cleared", 32'(reg_mode), 32'd0);
        checkOutput("srst_cmd_cleared", 32'(cmd_data), 32'd0);
        spi_resetn = 1'b1;
        repeat (5) @(negedge clk);

        checkOutput("cmd_queue_drained", 32'(cmd_q.size()), 32'd0);
        checkOutput("sample_req_count", 32'(sreq_cnt), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
